// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the packet processing scheduler.
package pkt_sched_pkg;

    // Scheduler states; encodings are visible on state_dbg.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RX    = 3'd1,
        ST_PROC  = 3'd2,
        ST_TX    = 3'd3,
        ST_FLUSH = 3'd4
    } sched_state_e;

    // Control-lane values: a header word and a plain payload word.
    localparam logic [7:0] CTRL_HDR  = 8'hFF;
    localparam logic [7:0] CTRL_NONE = 8'h00;

    // Slot assignment of the statistics counters inside sched_stats.
    localparam int NUM_STATS = 3;
    localparam int STAT_PKT  = 0;
    localparam int STAT_DROP = 1;
    localparam int STAT_TMO  = 2;

endpackage

// File: rtl/sched_stats.sv
// Statistics block: one free-running wrap-around counter per increment strobe.
module sched_stats
    import pkt_sched_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_STATS-1:0]                  i_inc,
    output logic [NUM_STATS-1:0][CNT_WIDTH-1:0]   o_counts
);

    generate
        for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] r_count;

            // Count one event per strobe cycle; wraps naturally at 2^CNT_WIDTH.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_count <= '0;
                end else if (i_inc[gi]) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_counts[gi] = r_count;
        end
    endgenerate

endmodule

// File: rtl/pkt_proc_sched.sv
// Packet scheduler: admits one packet into the shared FIFO, runs the core on
// it, then drains it downstream or discards it on overflow/timeout.
module pkt_proc_sched
    import pkt_sched_pkg::*;
#(
    parameter int CTRL_WIDTH = 8,
    parameter int MAX_WORDS  = 1023,
    parameter int TMO_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_wr,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  in_rdy,
    input  logic                  fifo_almfull,
    input  logic                  fifo_empty,
    input  logic                  core_done,
    output logic                  pc_en,
    output logic                  core_restart,
    output logic                  drain_en,
    output logic                  out_discard,
    input  logic                  cfg_enable,
    input  logic [TMO_WIDTH-1:0]  cfg_timeout,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [CNT_WIDTH-1:0]  tmo_count,
    output logic [2:0]            state_dbg
);

    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam logic [WCW-1:0]        LP_MAX_WORDS = WCW'(MAX_WORDS);
    localparam logic [WCW-1:0]        LP_MIN_LAST  = WCW'(2);
    localparam logic [CTRL_WIDTH-1:0] LP_CTRL_NONE = CTRL_WIDTH'(CTRL_NONE);

    sched_state_e                        r_state;
    sched_state_e                        w_state_next;
    logic [WCW-1:0]                      r_word_cnt;
    logic [WCW-1:0]                      w_word_cnt_inc;
    logic [TMO_WIDTH-1:0]                r_tmo_cnt;
    logic                                r_core_restart;
    logic                                w_restart_set;
    logic                                w_accept;
    logic                                w_is_ctrl;
    logic                                w_tmo_hit;
    logic                                w_pkt_inc;
    logic                                w_drop_inc;
    logic                                w_tmo_inc;
    logic [NUM_STATS-1:0]                w_stat_inc;
    logic [NUM_STATS-1:0][CNT_WIDTH-1:0] w_counts;

    // Upstream handshake; a packet in RX finishes even if admission is disabled.
    assign in_rdy = (((r_state == ST_IDLE) & cfg_enable) | (r_state == ST_RX))
                    & ~fifo_almfull;

    assign w_accept       = in_wr & in_rdy;
    assign w_is_ctrl      = (in_ctrl != LP_CTRL_NONE);
    assign w_word_cnt_inc = r_word_cnt + 1'b1;
    assign w_tmo_hit      = (cfg_timeout != '0) && (r_tmo_cnt == cfg_timeout - 1'b1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Word counter, processing-time counter and the restart pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_cnt     <= '0;
            r_tmo_cnt      <= '0;
            r_core_restart <= 1'b0;
        end else begin
            r_core_restart <= w_restart_set;
            if (r_state == ST_IDLE && w_accept) begin
                r_word_cnt <= WCW'(1);
            end else if (r_state == ST_RX && w_accept) begin
                r_word_cnt <= w_word_cnt_inc;
            end
            // Cleared outside PROC so it restarts from 0 on every PROC entry.
            if (r_state == ST_PROC) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    // Next-state logic and statistics strobes.
    always_comb begin
        w_state_next  = r_state;
        w_restart_set = 1'b0;
        w_pkt_inc     = 1'b0;
        w_drop_inc    = 1'b0;
        w_tmo_inc     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_ctrl) begin
                        w_state_next = ST_RX;
                    end else begin
                        // Payload without a header: discard whatever landed in the FIFO.
                        w_state_next = ST_FLUSH;
                        w_drop_inc   = 1'b1;
                    end
                end
            end
            ST_RX: begin
                if (w_accept) begin
                    if (w_is_ctrl && (r_word_cnt >= LP_MIN_LAST)) begin
                        w_state_next  = ST_PROC;
                        w_restart_set = 1'b1;
                    end else if (w_word_cnt_inc == LP_MAX_WORDS) begin
                        w_state_next = ST_FLUSH;
                        w_drop_inc   = 1'b1;
                    end
                end
            end
            ST_PROC: begin
                // core_done has priority over a coincident timeout.
                if (core_done) begin
                    w_state_next = ST_TX;
                end else if (w_tmo_hit) begin
                    w_state_next = ST_FLUSH;
                    w_tmo_inc    = 1'b1;
                end
            end
            ST_TX: begin
                if (fifo_empty) begin
                    w_state_next = ST_IDLE;
                    w_pkt_inc    = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (fifo_empty) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output decodes of the registered state.
    assign pc_en        = (r_state == ST_PROC);
    assign drain_en     = (r_state == ST_TX) | (r_state == ST_FLUSH);
    assign out_discard  = (r_state == ST_FLUSH);
    assign core_restart = r_core_restart;
    assign state_dbg    = r_state;

    assign w_stat_inc[STAT_PKT]  = w_pkt_inc;
    assign w_stat_inc[STAT_DROP] = w_drop_inc;
    assign w_stat_inc[STAT_TMO]  = w_tmo_inc;

    sched_stats #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stats (
        .clk      (clk),
        .reset    (reset),
        .i_inc    (w_stat_inc),
        .o_counts (w_counts)
    );

    assign pkt_count  = w_counts[STAT_PKT];
    assign drop_count = w_counts[STAT_DROP];
    assign tmo_count  = w_counts[STAT_TMO];

endmodule

// File: tb/tb_pkt_proc_sched.sv
// Scenario bench for pkt_proc_sched with a small FIFO occupancy model and a
// scoreboard of expected packet outcomes.
module tb_pkt_proc_sched;
    import pkt_sched_pkg::*;

    localparam int CW = 8;
    localparam int MW = 8;
    localparam int TW = 16;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_wr = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_rdy;
    logic          fifo_almfull = 1'b0;
    logic          fifo_empty;
    logic          core_done = 1'b0;
    logic          pc_en;
    logic          core_restart;
    logic          drain_en;
    logic          out_discard;
    logic          cfg_enable = 1'b1;
    logic [TW-1:0] cfg_timeout = 16'd100;
    logic [NW-1:0] pkt_count;
    logic [NW-1:0] drop_count;
    logic [NW-1:0] tmo_count;
    logic [2:0]    state_dbg;

    typedef struct {
        logic [2:0] kind;
        int         pc_cycles;
        logic       discard;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fifo_level;
    int   restart_hi;

    always #5 clk = ~clk;

    pkt_proc_sched #(
        .CTRL_WIDTH (CW),
        .MAX_WORDS  (MW),
        .TMO_WIDTH  (TW),
        .CNT_WIDTH  (NW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_wr        (in_wr),
        .in_ctrl      (in_ctrl),
        .in_rdy       (in_rdy),
        .fifo_almfull (fifo_almfull),
        .fifo_empty   (fifo_empty),
        .core_done    (core_done),
        .pc_en        (pc_en),
        .core_restart (core_restart),
        .drain_en     (drain_en),
        .out_discard  (out_discard),
        .cfg_enable   (cfg_enable),
        .cfg_timeout  (cfg_timeout),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count),
        .tmo_count    (tmo_count),
        .state_dbg    (state_dbg)
    );

    // FIFO occupancy model: filled by accepted words, drained one word per cycle.
    always @(posedge clk) begin
        if (reset) begin
            fifo_level <= 0;
        end else begin
            fifo_level <= fifo_level + ((in_wr && in_rdy) ? 1 : 0)
                          - ((drain_en && fifo_level > 0) ? 1 : 0);
        end
    end
    assign fifo_empty = (fifo_level == 0);

    // Count cycles with core_restart high.
    always @(negedge clk) begin
        if (reset) begin
            restart_hi <= 0;
        end else if (core_restart === 1'b1) begin
            restart_hi <= restart_hi + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; core_done = 1'b0;
        fifo_almfull = 1'b0; cfg_enable = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [CW-1:0] ctrl);
        in_wr = 1'b1;
        in_ctrl = ctrl;
        @(negedge clk);
        in_wr = 1'b0;
        in_ctrl = '0;
    endtask

    task automatic send_pkt(input int n_pay);
        send_word(CTRL_HDR);
        for (int i = 0; i < n_pay; i++) send_word(CTRL_NONE);
        send_word(8'h0F);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state_dbg === st) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Run the PROC phase; raise core_done in pc_en cycle done_at (0 = never).
    task automatic run_proc(input int done_at, output int cycles,
                            output logic [2:0] exit_st, output logic exit_disc);
        int guard;
        cycles = 0;
        guard = 0;
        while (pc_en !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        while (pc_en === 1'b1 && guard < 400) begin
            cycles++;
            if (cycles == done_at) core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
            guard++;
        end
        exit_st = state_dbg;
        exit_disc = out_discard;
        $display("pkt: pc_en cycles=%0d exit state=%0d discard=%0b", cycles, exit_st, exit_disc);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        checks++; if ({pc_en, core_restart, drain_en, out_discard} !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got %b want 0000", {pc_en, core_restart, drain_en, out_discard}); end
        checks++; if ({pkt_count, drop_count, tmo_count} !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", pkt_count, drop_count, tmo_count); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
        fifo_almfull = 1'b1;
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL almfull_in_rdy: got %b want 0", in_rdy); end
        fifo_almfull = 1'b0;
        cfg_enable = 1'b0;
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL disabled_idle_in_rdy: got %b want 0", in_rdy); end
        cfg_enable = 1'b1;
        $display("reset: state=%0d in_rdy=%b", state_dbg, in_rdy);
    endtask

    task automatic test_normal();
        exp_t e, got;
        int cyc;
        bit ok;
        do_reset();
        cfg_timeout = 16'd100;
        e.kind = ST_TX; e.pc_cycles = 21; e.discard = 1'b0;
        sb_q.push_back(e);
        send_pkt(3);
        checks++; if (core_restart !== 1'b1 || pc_en !== 1'b1) begin errors++; $display("FAIL normal_restart: got restart=%b pc_en=%b want 1/1", core_restart, pc_en); end
        run_proc(21, cyc, got.kind, got.discard);
        e = sb_q.pop_front();
        checks++; if (cyc !== e.pc_cycles) begin errors++; $display("FAIL normal_pc_cycles: got %0d want %0d", cyc, e.pc_cycles); end
        checks++; if (got.kind !== e.kind || got.discard !== e.discard) begin errors++; $display("FAIL normal_exit: got st=%0d disc=%b want st=%0d disc=%b", got.kind, got.discard, e.kind, e.discard); end
        checks++; if (drain_en !== 1'b1) begin errors++; $display("FAIL normal_drain_en: got %b want 1", drain_en); end
        wait_state(ST_IDLE, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL normal_return_idle: got state=%0d want 0", state_dbg); end
        checks++; if (pkt_count !== 32'd1 || drop_count !== 32'd0 || tmo_count !== 32'd0) begin errors++; $display("FAIL normal_counters: got %0d/%0d/%0d want 1/0/0", pkt_count, drop_count, tmo_count); end
        checks++; if (restart_hi !== 1) begin errors++; $display("FAIL normal_restart_pulses: got %0d want 1", restart_hi); end
        checks++; if (fifo_level !== 0) begin errors++; $display("FAIL normal_fifo_drained: got %0d want 0", fifo_level); end
    endtask

    task automatic test_timeout();
        exp_t e, got;
        int cyc;
        bit ok;
        do_reset();
        cfg_timeout = 16'd10;
        e.kind = ST_FLUSH; e.pc_cycles = 10; e.discard = 1'b1;
        sb_q.push_back(e);
        send_pkt(3);
        run_proc(0, cyc, got.kind, got.discard);
        e = sb_q.pop_front();
        checks++; if (cyc !== e.pc_cycles) begin errors++; $display("FAIL timeout_pc_cycles: got %0d want %0d", cyc, e.pc_cycles); end
        checks++; if (got.kind !== e.kind || got.discard !== e.discard) begin errors++; $display("FAIL timeout_exit: got st=%0d disc=%b want st=%0d disc=%b", got.kind, got.discard, e.kind, e.discard); end
        wait_state(ST_IDLE, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_return_idle: got state=%0d want 0", state_dbg); end
        checks++; if (pkt_count !== 32'd0 || drop_count !== 32'd0 || tmo_count !== 32'd1) begin errors++; $display("FAIL timeout_counters: got %0d/%0d/%0d want 0/0/1", pkt_count, drop_count, tmo_count); end
    endtask

    task automatic test_simul_done_timeout();
        exp_t e, got;
        int cyc;
        bit ok;
        do_reset();
        cfg_timeout = 16'd10;
        e.kind = ST_TX; e.pc_cycles = 10; e.discard = 1'b0;
        sb_q.push_back(e);
        send_pkt(2);
        run_proc(10, cyc, got.kind, got.discard);
        e = sb_q.pop_front();
        checks++; if (cyc !== e.pc_cycles) begin errors++; $display("FAIL simul_pc_cycles: got %0d want %0d", cyc, e.pc_cycles); end
        checks++; if (got.kind !== e.kind || got.discard !== e.discard) begin errors++; $display("FAIL simul_exit: got st=%0d disc=%b want st=%0d disc=%b", got.kind, got.discard, e.kind, e.discard); end
        wait_state(ST_IDLE, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_return_idle: got state=%0d want 0", state_dbg); end
        checks++; if (pkt_count !== 32'd1 || tmo_count !== 32'd0) begin errors++; $display("FAIL simul_counters: got pkt=%0d tmo=%0d want 1/0", pkt_count, tmo_count); end
    endtask

    task automatic test_overflow();
        int  accepted;
        bit  seen;
        bit  ok;
        do_reset();
        accepted = 0;
        seen = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (in_rdy === 1'b1) accepted++;
            send_word((i == 0) ? CTRL_HDR : CTRL_NONE);
            if (accepted == MW && !seen) begin
                seen = 1'b1;
                checks++; if (state_dbg !== ST_FLUSH || out_discard !== 1'b1) begin errors++; $display("FAIL overflow_flush: got st=%0d disc=%b want 4/1", state_dbg, out_discard); end
                checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL overflow_in_rdy: got %b want 0", in_rdy); end
                checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL overflow_drop_entry: got %0d want 1", drop_count); end
            end
        end
        $display("overflow: accepted=%0d words", accepted);
        checks++; if (accepted !== MW) begin errors++; $display("FAIL overflow_accepted: got %0d want %0d", accepted, MW); end
        wait_state(ST_IDLE, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL overflow_return_idle: got state=%0d want 0", state_dbg); end
        checks++; if (drop_count !== 32'd1 || pkt_count !== 32'd0 || pc_en !== 1'b0) begin errors++; $display("FAIL overflow_counters: got drop=%0d pkt=%0d pc_en=%b want 1/0/0", drop_count, pkt_count, pc_en); end
    endtask

    task automatic test_stray();
        bit ok;
        do_reset();
        send_word(CTRL_NONE);
        $display("stray: state=%0d discard=%b", state_dbg, out_discard);
        checks++; if (state_dbg !== ST_FLUSH || out_discard !== 1'b1 || drain_en !== 1'b1) begin errors++; $display("FAIL stray_flush: got st=%0d disc=%b drain=%b want 4/1/1", state_dbg, out_discard, drain_en); end
        checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL stray_drop: got %0d want 1", drop_count); end
        wait_state(ST_IDLE, 20, ok);
        checks++; if (!ok || in_rdy !== 1'b1) begin errors++; $display("FAIL stray_recover: got st=%0d in_rdy=%b want 0/1", state_dbg, in_rdy); end
    endtask

    task automatic test_disable_mid_packet();
        exp_t e, got;
        int cyc;
        bit ok;
        do_reset();
        cfg_timeout = 16'd100;
        e.kind = ST_TX; e.pc_cycles = 5; e.discard = 1'b0;
        sb_q.push_back(e);
        send_word(CTRL_HDR);
        send_word(CTRL_NONE);
        cfg_enable = 1'b0;
        #1;
        checks++; if (in_rdy !== 1'b1 || state_dbg !== ST_RX) begin errors++; $display("FAIL disable_rx_in_rdy: got in_rdy=%b st=%0d want 1/1", in_rdy, state_dbg); end
        send_word(CTRL_NONE);
        send_word(8'h0F);
        run_proc(5, cyc, got.kind, got.discard);
        e = sb_q.pop_front();
        checks++; if (cyc !== e.pc_cycles || got.kind !== e.kind) begin errors++; $display("FAIL disable_exit: got cyc=%0d st=%0d want %0d/%0d", cyc, got.kind, e.pc_cycles, e.kind); end
        wait_state(ST_IDLE, 50, ok);
        checks++; if (!ok || pkt_count !== 32'd1) begin errors++; $display("FAIL disable_pkt_count: got st=%0d pkt=%0d want 0/1", state_dbg, pkt_count); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL disable_idle_in_rdy: got %b want 0", in_rdy); end
        send_word(CTRL_HDR);
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL disable_ignored_word: got st=%0d want 0", state_dbg); end
        cfg_enable = 1'b1;
    endtask

    task automatic test_reset_in_proc();
        exp_t e, got;
        int cyc;
        bit ok;
        do_reset();
        cfg_timeout = 16'd100;
        e.kind = ST_TX; e.pc_cycles = 3; e.discard = 1'b0;
        sb_q.push_back(e);
        send_pkt(1);
        run_proc(3, cyc, got.kind, got.discard);
        e = sb_q.pop_front();
        checks++; if (cyc !== e.pc_cycles || got.kind !== e.kind) begin errors++; $display("FAIL rstproc_first_pkt: got cyc=%0d st=%0d want %0d/%0d", cyc, got.kind, e.pc_cycles, e.kind); end
        wait_state(ST_IDLE, 50, ok);
        checks++; if (!ok || pkt_count !== 32'd1) begin errors++; $display("FAIL rstproc_pkt_before: got st=%0d pkt=%0d want 0/1", state_dbg, pkt_count); end
        send_pkt(2);
        repeat (3) @(negedge clk);
        checks++; if (pc_en !== 1'b1 || state_dbg !== ST_PROC) begin errors++; $display("FAIL rstproc_in_proc: got pc_en=%b st=%0d want 1/2", pc_en, state_dbg); end
        reset = 1'b1;
        @(negedge clk);
        $display("reset in PROC: state=%0d pc_en=%b pkt=%0d", state_dbg, pc_en, pkt_count);
        checks++; if (state_dbg !== ST_IDLE || pc_en !== 1'b0 || drain_en !== 1'b0 || core_restart !== 1'b0) begin errors++; $display("FAIL rstproc_state: got st=%0d pc_en=%b drain=%b rst=%b want 0/0/0/0", state_dbg, pc_en, drain_en, core_restart); end
        checks++; if (pkt_count !== 32'd0 || drop_count !== 32'd0 || tmo_count !== 32'd0) begin errors++; $display("FAIL rstproc_counters: got %0d/%0d/%0d want 0/0/0", pkt_count, drop_count, tmo_count); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_simul_done_timeout();
        test_overflow();
        test_stray();
        test_disable_mid_packet();
        test_reset_in_proc();
        checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_proc_sched.md
# pkt_proc_sched

Packet-level scheduler that sequences the shared packet FIFO/SRAM and the embedded RISC-V datapath. It admits one packet at a time into the FIFO, runs the core on it by gating `pc_en`, and then either forwards the processed packet downstream or flushes it on timeout or overflow. It sits between the upstream packet interface and the `fifo_sram`/`datapath` pair, replacing direct software control of `pc_en` and `out_rdy`.

## Interface
Parameters:
- `CTRL_WIDTH`, 8: width of the packet control lane.
- `MAX_WORDS`, 1023: largest packet length in 72-bit words. Matches the FIFO address range.
- `TMO_WIDTH`, 16: width of the processing-timeout counter.
- `CNT_WIDTH`, 32: width of the statistics counters.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_wr`  in  1  upstream word valid.
- `in_ctrl`  in  CTRL_WIDTH  upstream control lane. Nonzero marks the module header or the last word.
- `in_rdy`  out  1  this block accepts upstream words.
- `fifo_almfull`  in  1  FIFO almost full.
- `fifo_empty`  in  1  FIFO empty.
- `core_done`  in  1  core reports that packet processing is finished (level or pulse).
- `pc_en`  out  1  core run enable.
- `core_restart`  out  1  one-cycle pulse that resets the core PC to 0.
- `drain_en`  out  1  drives the FIFO `out_rdy`.
- `out_discard`  out  1  downstream must suppress `out_wr`.
- `cfg_enable`  in  1  admit new packets.
- `cfg_timeout`  in  TMO_WIDTH  processing cycle limit. 0 disables the timeout.
- `pkt_count`, `drop_count`, `tmo_count`  out  CNT_WIDTH each  statistics counters.
- `state_dbg`  out  3  current state encoding.

## Operation
States are IDLE, RX, PROC, TX and FLUSH.
- **IDLE:**
  - A word is accepted when `in_wr & in_rdy`.
  - An accepted word with `in_ctrl != 0` moves to RX with `word_cnt = 1`.
  - An accepted word with `in_ctrl == 0` is a stray payload word. Go to FLUSH and count it as a drop.
- **RX:**
  - Each accepted word increments `word_cnt`.
  - An accepted word with `in_ctrl != 0` and `word_cnt >= 2` (so at least one payload word has been seen) is the last word. Go to PROC and pulse `core_restart` in that same cycle.
  - If `word_cnt` reaches `MAX_WORDS` without a last word, go to FLUSH and count a drop.
- **PROC:**
  - `pc_en = 1`. `tmo_cnt` increments every cycle starting from 0.
  - `core_done` moves to TX.
  - Otherwise, if `cfg_timeout != 0` and `tmo_cnt == cfg_timeout - 1`, move to FLUSH and increment `tmo_count`.
  - If `core_done` and the timeout condition occur in the same cycle, `core_done` wins.
- **TX:** `drain_en = 1`. When `fifo_empty` is seen, increment `pkt_count` and return to IDLE.
- **FLUSH:** `drain_en = 1`, `out_discard = 1`. When `fifo_empty` is seen, return to IDLE. `drop_count` increments once on FLUSH entry from IDLE or RX; timeout entries count only in `tmo_count`.
- `in_rdy = (state == IDLE | state == RX) & ~fifo_almfull`, additionally qualified by `cfg_enable` in IDLE only. A packet already in RX completes regardless of `cfg_enable`.
- Words offered while `in_rdy = 0` are ignored and not counted.
- All statistics counters wrap modulo 2^CNT_WIDTH.

## Timing
- **Reset values:** state IDLE; `pc_en`, `core_restart`, `drain_en` and `out_discard` all 0; all counters 0.
- **Reset mid-operation:** return to IDLE in the next cycle. No counter increments. The FIFO is not flushed by this block.
- **Output timing:**
  - `pc_en`, `drain_en`, `out_discard` and `state_dbg` are registered state decodes, valid the cycle after the transition edge.
  - `in_rdy` is combinational from the state register and `fifo_almfull`.
- **Latencies:**
  - Last word accepted at cycle N → `core_restart = 1` at N+1 and `pc_en = 1` from N+1.
  - `core_done` sampled at cycle M → `pc_en = 0` and `drain_en = 1` at M+1.
- **FIFO empty at drain entry:** if `fifo_empty` is already 1 when TX or FLUSH is entered, the block still spends exactly one cycle in that state.

## Structure
- Shared package `pkt_sched_pkg` holds:
  - the state enum (IDLE=0, RX=1, PROC=2, TX=3, FLUSH=4);
  - the constants `CTRL_HDR = 8'hFF` and `CTRL_NONE = 8'h00`.
- One sub-module, `sched_stats`, contains the three saturating-free wrap counters with increment strobes. All other logic stays flat.

## Test plan
- **Normal packet:**
  - Stimulus: `cfg_timeout = 100`; header (ctrl FF), 3 payload words (ctrl 00), last word (ctrl 0F); `core_done` 20 cycles later.
  - Required: one `core_restart` pulse; `pc_en` high for exactly 21 cycles; drain until empty; `pkt_count = 1`.
- **Timeout:** same packet with `cfg_timeout = 10` and no `core_done` → `pc_en` high 10 cycles, then FLUSH with `out_discard = 1`, `tmo_count = 1`, `pkt_count = 0`.
- **Overflow:** `MAX_WORDS = 8`; header followed by 10 payload words → FLUSH after the 8th accepted word, `drop_count = 1`, `in_rdy = 0` from the next cycle.
- **Simultaneous done/timeout:** `core_done` asserted in the exact timeout cycle → TX, not FLUSH; `tmo_count` unchanged.
- **Disable mid-packet:** `cfg_enable` dropped during RX → the current packet completes to `pkt_count = 1`, and `in_rdy` stays 0 in IDLE afterwards.
- **Reset in PROC:** `reset` asserted in PROC → next cycle IDLE with `pc_en = 0` and all counters 0.
